dec_onehot_seq: RTL and testbench

//  Parametrised, registered binary-to-one-hot decoder for the processor's register-file write-select path.

---
 rtl/dec_onehot_seq_pkg.sv | 18 +
 rtl/dec_onehot_seq_if.sv | 26 ++
 rtl/dec_onehot_seq_dec.sv | 13 +
 rtl/dec_onehot_seq.sv | 110 +++++++++++
 tb/tb_dec_onehot_seq.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/dec_onehot_seq_pkg.sv
// Shared definitions for the register-file write-select decoder: state encoding,
// default instance sizing and the hold-counter width helper.
package dec_onehot_seq_pkg;

    typedef enum logic {
        DEC_IDLE  = 1'b0,
        DEC_SWEEP = 1'b1
    } dec_state_e;

    localparam int RF_SEL_W       = 3;
    localparam int RF_HOLD_CYCLES = 1;

    // A one-cycle hold still needs a 1-bit counter so the compare stays well-formed.
    function automatic int hold_cnt_w(input int hold_cycles);
        return (hold_cycles <= 1) ? 1 : $clog2(hold_cycles);
    endfunction

endpackage

// File: rtl/dec_onehot_seq_if.sv
// Select/status bundle between the control unit (master) and the write-select decoder (slave).
interface dec_onehot_seq_if #(
    parameter int SEL_W = 3
);
    localparam int OUT_W = 1 << SEL_W;

    logic [SEL_W-1:0] w;
    logic             en;
    logic             sweep;
    logic             abort;
    logic [OUT_W-1:0] y;
    logic [SEL_W-1:0] index;
    logic             busy;
    logic             done;

    modport master (
        output w, en, sweep, abort,
        input  y, index, busy, done
    );

    modport slave (
        input  w, en, sweep, abort,
        output y, index, busy, done
    );

endinterface

// File: rtl/dec_onehot_seq_dec.sv
// Combinational SEL_W-to-OUT_W one-hot decoder with enable; all-zero when disabled.
module dec_onehot #(
    parameter int SEL_W = 3,
    parameter int OUT_W = 1 << SEL_W
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [OUT_W-1:0] y
);

    assign y = en ? (OUT_W'(1) << sel) : '0;

endmodule

// File: rtl/dec_onehot_seq.sv
// Registered binary-to-one-hot write-select decoder with a sweep mode that walks every
// output in turn, holding each for HOLD_CYCLES cycles, to initialise the register file.
module dec_onehot_seq
    import dec_onehot_seq_pkg::*;
#(
    parameter int SEL_W       = RF_SEL_W,
    parameter int HOLD_CYCLES = RF_HOLD_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    dec_onehot_seq_if.slave  bus
);

    localparam int OUT_W  = 1 << SEL_W;
    localparam int HOLD_W = hold_cnt_w(HOLD_CYCLES);

    dec_state_e        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [SEL_W-1:0]  index_q;
    logic [OUT_W-1:0]  y_q;
    logic              busy_q;
    logic              done_q;

    logic              last_hold;
    logic              last_idx;
    logic [SEL_W-1:0]  dec_sel;
    logic              dec_en;
    logic [OUT_W-1:0]  dec_y;

    assign last_hold = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
    assign last_idx  = (index_q == SEL_W'(OUT_W - 1));

    // One decoder serves both modes: next sweep slot while sweeping, else the
    // sweep start slot (0) or the direct select.
    always_comb begin
        dec_sel = bus.w;
        dec_en  = bus.en;
        if (state == DEC_SWEEP) begin
            dec_sel = index_q + 1'b1;
            dec_en  = 1'b1;
        end else if (bus.sweep) begin
            dec_sel = '0;
            dec_en  = 1'b1;
        end
    end

    dec_onehot #(
        .SEL_W (SEL_W),
        .OUT_W (OUT_W)
    ) u_dec (
        .sel (dec_sel),
        .en  (dec_en),
        .y   (dec_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= DEC_IDLE;
            hold_cnt <= '0;
            index_q  <= '0;
            y_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                DEC_IDLE: begin
                    done_q <= 1'b0;
                    y_q    <= dec_y;
                    if (bus.sweep) begin
                        state    <= DEC_SWEEP;
                        index_q  <= '0;
                        hold_cnt <= '0;
                        busy_q   <= 1'b1;
                    end else if (bus.en) begin
                        index_q <= bus.w;
                    end
                end
                DEC_SWEEP: begin
                    // Abort wins over completion; neither path raises done on abort.
                    if (bus.abort) begin
                        state    <= DEC_IDLE;
                        hold_cnt <= '0;
                        y_q      <= '0;
                        busy_q   <= 1'b0;
                    end else if (last_hold) begin
                        hold_cnt <= '0;
                        if (last_idx) begin
                            state  <= DEC_IDLE;
                            y_q    <= '0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            index_q <= index_q + 1'b1;
                            y_q     <= dec_y;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= DEC_IDLE;
            endcase
        end
    end

    assign bus.y     = y_q;
    assign bus.index = index_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_dec_onehot_seq.sv
// Bench for dec_onehot_seq: three sizings driven in lock-step, compared each cycle against
// a sweep-position model, plus directed checks of the documented scenarios.
module tb_dec_onehot_seq;

    localparam int NI = 3;
    localparam int SWA [NI] = '{3, 3, 4};
    localparam int HA  [NI] = '{1, 3, 1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] w4 = '0;
    logic       en = 1'b0, sweep = 1'b0, abort = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dec_onehot_seq_if #(.SEL_W(3)) if0 ();
    dec_onehot_seq_if #(.SEL_W(3)) if1 ();
    dec_onehot_seq_if #(.SEL_W(4)) if2 ();

    dec_onehot_seq #(.SEL_W(3), .HOLD_CYCLES(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    dec_onehot_seq #(.SEL_W(3), .HOLD_CYCLES(3)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    dec_onehot_seq #(.SEL_W(4), .HOLD_CYCLES(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    assign if0.w = w4[2:0]; assign if0.en = en; assign if0.sweep = sweep; assign if0.abort = abort;
    assign if1.w = w4[2:0]; assign if1.en = en; assign if1.sweep = sweep; assign if1.abort = abort;
    assign if2.w = w4;      assign if2.en = en; assign if2.sweep = sweep; assign if2.abort = abort;

    logic [15:0] dy [NI];
    logic [3:0]  di [NI];
    logic        db [NI];
    logic        dd [NI];

    assign dy[0] = 16'(if0.y); assign di[0] = {1'b0, if0.index}; assign db[0] = if0.busy; assign dd[0] = if0.done;
    assign dy[1] = 16'(if1.y); assign di[1] = {1'b0, if1.index}; assign db[1] = if1.busy; assign dd[1] = if1.done;
    assign dy[2] = if2.y;      assign di[2] = if2.index;         assign db[2] = if2.busy; assign dd[2] = if2.done;

    // Reference: a sweep is a position 0..OUT_W*HOLD-1; the live output is pos/HOLD.
    bit          m_act  [NI];
    int          m_pos  [NI];
    logic [3:0]  m_idx  [NI];
    logic [15:0] m_y    [NI];
    bit          m_busy [NI];
    bit          m_done [NI];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NI; k++) begin
                m_act[k] <= 0; m_pos[k] <= 0; m_idx[k] <= '0;
                m_y[k] <= '0; m_busy[k] <= 0; m_done[k] <= 0;
            end
        end else begin
            for (int k = 0; k < NI; k++) begin
                if (m_act[k]) begin
                    if (abort) begin
                        m_act[k] <= 0; m_y[k] <= '0; m_busy[k] <= 0; m_done[k] <= 0;
                    end else if (m_pos[k] == (1 << SWA[k]) * HA[k] - 1) begin
                        m_act[k] <= 0; m_y[k] <= '0; m_busy[k] <= 0; m_done[k] <= 1;
                    end else begin
                        m_pos[k] <= m_pos[k] + 1;
                        m_idx[k] <= 4'((m_pos[k] + 1) / HA[k]);
                        m_y[k]   <= 16'(1) << ((m_pos[k] + 1) / HA[k]);
                        m_done[k] <= 0;
                    end
                end else begin
                    m_done[k] <= 0;
                    if (sweep) begin
                        m_act[k] <= 1; m_pos[k] <= 0; m_idx[k] <= '0;
                        m_y[k] <= 16'(1); m_busy[k] <= 1;
                    end else if (en) begin
                        m_idx[k] <= 4'(int'(w4) % (1 << SWA[k]));
                        m_y[k]   <= 16'(1) << (int'(w4) % (1 << SWA[k]));
                    end else begin
                        m_y[k] <= '0;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d]: observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < NI; k++) begin
            chk({tag, ".y"},     k, dy[k], m_y[k]);
            chk({tag, ".index"}, k, 16'(di[k]), 16'(m_idx[k]));
            chk({tag, ".busy"},  k, 16'(db[k]), 16'(m_busy[k]));
            chk({tag, ".done"},  k, 16'(dd[k]), 16'(m_done[k]));
            chk({tag, ".onehot"}, k, 16'($countones(dy[k]) <= 1), 16'(1));
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    int bc [NI];
    int dc [NI];

    initial begin
        // reset state
        #3;
        check_all("reset");
        chk("reset_y", 0, dy[0], 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // direct decode
        w4 = 4'd5; en = 1'b1;
        tick("direct");
        chk("direct_y5", 0, dy[0], 16'h0020);
        chk("direct_idx5", 0, 16'(di[0]), 16'd5);
        en = 1'b0; w4 = 4'd1;
        tick("direct_off");
        chk("off_y", 0, dy[0], 16'h0000);
        chk("off_idx_hold", 0, 16'(di[0]), 16'd5);

        // single-pulse sweep; H=1/8 steps, H=3/24 cycles, SEL_W=4/16 steps
        for (int k = 0; k < NI; k++) begin bc[k] = 0; dc[k] = 0; end
        sweep = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick("sweep");
            if (c == 0) sweep = 1'b0;
            if (c == 8) chk("sweep_done_h1", 0, 16'(dd[0]), 16'd1);
            for (int k = 0; k < NI; k++) begin
                bc[k] += int'(db[k]);
                dc[k] += int'(dd[k]);
            end
        end
        chk("busy_cnt_h1", 0, 16'(bc[0]), 16'd8);
        chk("busy_cnt_h3", 1, 16'(bc[1]), 16'd24);
        chk("busy_cnt_sel4", 2, 16'(bc[2]), 16'd16);
        chk("done_cnt_h3", 1, 16'(dc[1]), 16'd1);

        // abort while index=3 on the H=1 instance
        sweep = 1'b1;
        tick("abort_start");
        sweep = 1'b0;
        repeat (3) tick("abort_run");
        chk("abort_pre_idx", 0, 16'(di[0]), 16'd3);
        abort = 1'b1;
        tick("abort");
        abort = 1'b0;
        chk("abort_y", 0, dy[0], 16'h0000);
        chk("abort_busy", 0, 16'(db[0]), 16'd0);
        chk("abort_idx_hold", 0, 16'(di[0]), 16'd3);
        repeat (3) tick("post_abort");
        w4 = 4'd2; en = 1'b1;
        tick("after_abort_decode");
        chk("after_abort_y", 0, dy[0], 16'h0004);
        en = 1'b0;
        tick("idle");

        // sweep ignoring W/En, then async reset between edges
        sweep = 1'b1;
        tick("rst_sweep_start");
        sweep = 1'b0;
        for (int c = 0; c < 4; c++) begin
            w4 = 4'($urandom); en = 1'($urandom);
            tick("sweep_toggle");
        end
        #2 rst_n = 1'b0;
        #1;
        check_all("async_rst");
        for (int k = 0; k < NI; k++) begin
            chk("async_rst_y", k, dy[k], 16'h0000);
            chk("async_rst_busy", k, 16'(db[k]), 16'd0);
        end
        @(negedge clk);
        rst_n = 1'b1; en = 1'b0;

        // sweep held high: back-to-back sweeps on the 16-output instance
        sweep = 1'b1;
        dc[2] = 0;
        for (int c = 0; c < 40; c++) begin
            en = 1'($urandom); w4 = 4'($urandom);
            tick("sweep_held");
            dc[2] += int'(dd[2]);
        end
        chk("b2b_done_cnt", 2, 16'(dc[2]), 16'd2);
        sweep = 1'b0; en = 1'b0;

        // randomized traffic including abort and mid-cycle async reset
        for (int c = 0; c < 400; c++) begin
            w4    = 4'($urandom);
            en    = 1'($urandom);
            sweep = ($urandom_range(0, 9) == 0);
            abort = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 79) == 0) begin
                #2 rst_n = 1'b0;
                #1 check_all("rand_rst");
                @(negedge clk);
                rst_n = 1'b1;
            end
            tick("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
